instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single PC register plus IF/ID latch of the 5-stage core. It issues in-order requests to instruction memory and keeps up to DEPTH requests in flight. Returned instructions are buffered with their PC and PC+4 in a FIFO. Decode drains the FIFO through a valid/ready handshake. A branch/jump redirect flushes the queue and discards stale in-flight responses, so a multi-cycle or pipelined instruction memory no longer stalls the core on every fetch.

Parameters:
ADDR_WIDTH   32        width of PC and memory address
DATA_WIDTH   32        instruction width
DEPTH        4         FIFO entries and maximum outstanding requests; power of 2, >= 2
RESET_PC     32'h0     fetch address after reset (ADDR_WIDTH bits)

Ports:
clock__i          in   1           core clock, rising edge
reset__i          in   1           synchronous, active-high reset
redirect__i       in   1           branch/jump taken; flush and restart at redirectPc__i
redirectPc__i     in   ADDR_WIDTH  new fetch address, word aligned
imemReq__o        out  1           fetch request valid
imemAddr__o       out  ADDR_WIDTH  fetch address
imemGnt__i        in   1           request accepted this cycle (req & gnt = issue)
imemRvalid__i     in   1           response valid; responses return in issue order
imemRdata__i      in   DATA_WIDTH  response instruction
instrValid__o     out  1           FIFO head valid
instrReady__i     in   1           decode accepts head (valid & ready = pop)
instr__o          out  DATA_WIDTH  head instruction
pc__o             out  ADDR_WIDTH  head instruction address
pcPlus4__o        out  ADDR_WIDTH  pc__o + 4

Behaviour:
- State registers:
  - fetchPc: next address to issue.
  - respPc: PC of the next non-discarded response.
  - outstanding: 0..DEPTH; counts all in-flight requests, including those to be discarded.
  - discard: 0..DEPTH.
  - FIFO count: 0..DEPTH, plus rd/wr pointers that wrap modulo DEPTH.
- Reset (synchronous; takes priority over everything):
  - fetchPc = respPc = RESET_PC.
  - count = outstanding = discard = 0; pointers = 0.
  - Outputs: imemReq__o = 0, instrValid__o = 0. instr__o, pc__o and pcPlus4__o are don't-care while invalid.
  - Reset mid-operation: responses to requests issued before reset arriving afterwards are undefined (memory must also be reset).
- Issue: imemReq__o = !redirect__i && (count + outstanding < DEPTH), combinational. imemAddr__o = fetchPc.
  - On issue (req & gnt): fetchPc += 4 with ADDR_WIDTH wrap-around (0xFFFF_FFFC -> 0x0), and outstanding += 1.
  - Req may stay high across cycles while gnt is low; address is held.
- Response (imemRvalid__i):
  - Always outstanding -= 1.
  - If discard != 0: drop the data and discard -= 1.
  - Else push {imemRdata__i, respPc} at wrPtr and respPc += 4.
  - The credit rule guarantees a push never hits a full FIFO. A push while full is a bench assertion failure.
- Pop: instrValid__o = (count != 0). Head outputs are read combinationally from rdPtr. On valid & ready: rdPtr++, count -= 1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A pushed entry is visible on the outputs the cycle after rvalid. Minimum fetch-to-decode latency with a 1-cycle memory is 2 cycles.
- Redirect (redirect__i = 1 in cycle t):
  - Queue flushed: count = 0 and rdPtr = wrPtr. A pop in cycle t is ignored; decode must treat the head as killed.
  - Any rvalid in cycle t is dropped.
  - Next-state values: fetchPc = respPc = redirectPc__i; outstanding = outstanding - rvalid; discard = that same new outstanding.
  - No issue in cycle t. First request with redirectPc__i goes out in t+1.
  - Back-to-back redirects: the last one wins, and discard is recomputed each cycle.
- Invariants (bench asserts):
  - count + outstanding <= DEPTH.
  - discard <= outstanding.
  - imemRvalid__i is never asserted while outstanding == 0.
- pcPlus4__o = pc__o + 4, truncated to ADDR_WIDTH.

Test Plan:
- Reset, 1-cycle memory (gnt = 1, rvalid one cycle after issue), ready = 1 -> addresses 0x0, 0x4, 0x8… issued each cycle; instr/pc stream 0x0, 0x4… at one per cycle after 2-cycle startup; pcPlus4__o = pc + 4.
- instrReady__i = 0 for 20 cycles, DEPTH = 4 -> exactly 4 requests issued, count = 4, imemReq__o = 0. On raising ready, entries 0x0..0xC pop in order and issue resumes at 0x10.
- 3-cycle-latency memory, 3 requests in flight (0x20, 0x24, 0x28), redirect to 0x100 -> the 3 stale responses are dropped. First valid output has pc = 0x100 with 0x100's data; no 0x2x PC ever appears after redirect.
- Redirect coincident with rvalid and ready = 1 -> that response is dropped, the pop is ignored, discard = outstanding - 1, and the next issue address is redirectPc__i.
- Redirect to 0xFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pcPlus4__o of the second entry = 0x0.
- reset__i asserted while count = 2 and outstanding = 2 -> next cycle instrValid__o = 0, imemReq__o = 0; following cycle issue restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// Instruction prefetch queue bus bundle.
// Carries the redirect request, the instruction-memory request/response
// channel and the decode-side valid/ready channel.
//   master : the prefetch queue (drives fetch requests and the decode head)
//   slave  : the environment (core control, instruction memory, decode)
interface instr_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect__i;
  logic [ADDR_WIDTH-1:0] redirectPc__i;
  logic                  imemReq__o;
  logic [ADDR_WIDTH-1:0] imemAddr__o;
  logic                  imemGnt__i;
  logic                  imemRvalid__i;
  logic [DATA_WIDTH-1:0] imemRdata__i;
  logic                  instrValid__o;
  logic                  instrReady__i;
  logic [DATA_WIDTH-1:0] instr__o;
  logic [ADDR_WIDTH-1:0] pc__o;
  logic [ADDR_WIDTH-1:0] pcPlus4__o;

  modport master (
    input  redirect__i, redirectPc__i, imemGnt__i, imemRvalid__i, imemRdata__i,
           instrReady__i,
    output imemReq__o, imemAddr__o, instrValid__o, instr__o, pc__o, pcPlus4__o
  );

  modport slave (
    output redirect__i, redirectPc__i, imemGnt__i, imemRvalid__i, imemRdata__i,
           instrReady__i,
    input  imemReq__o, imemAddr__o, instrValid__o, instr__o, pc__o, pcPlus4__o
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: in-order fetch front end with up to DEPTH
// requests in flight and a DEPTH-entry FIFO of {instr, pc} for decode.
// Ports:
//   clock__i  core clock, rising edge
//   reset__i  synchronous active-high reset
//   bus       instr_prefetch_queue_if.master: redirect, imem req/gnt,
//             imem rvalid/rdata, decode valid/ready with instr/pc/pc+4
// A redirect flushes the FIFO and marks every in-flight request as stale;
// stale responses are counted down in discard_q and dropped on arrival.
module instr_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock__i,
  input  logic                  reset__i,
  instr_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]           DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q,  resp_pc_d;
  logic [CW-1:0]         outst_q,    outst_d;
  logic [CW-1:0]         discard_q,  discard_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;

  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic credit, req, issue, push, pop, valid;

  // Credit counts FIFO entries plus in-flight requests, so every response
  // that is not discarded always finds a free slot.
  assign credit = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;
  assign req    = !reset__i && !bus.redirect__i && credit;
  assign issue  = req && bus.imemGnt__i;
  assign push   = bus.imemRvalid__i && !bus.redirect__i && (discard_q == '0);
  assign valid  = !reset__i && (count_q != '0);
  assign pop    = valid && bus.instrReady__i && !bus.redirect__i;

  assign bus.imemReq__o    = req;
  assign bus.imemAddr__o   = fetch_pc_q;
  assign bus.instrValid__o = valid;
  assign bus.instr__o      = instr_mem_q[rd_ptr_q];
  assign bus.pc__o         = pc_mem_q[rd_ptr_q];
  assign bus.pcPlus4__o    = pc_mem_q[rd_ptr_q] + PC_STEP;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect__i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = bus.redirectPc__i;
      resp_pc_d  = bus.redirectPc__i;
      outst_d    = outst_q - CW'(bus.imemRvalid__i);
      discard_d  = outst_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      outst_d = outst_q + CW'(issue) - CW'(bus.imemRvalid__i);
      if (bus.imemRvalid__i && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + PC_STEP;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock__i) begin
    if (push && !reset__i) begin
      instr_mem_q[wr_ptr_q] <= bus.imemRdata__i;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model
// (requests in flight tagged stale on redirect; FIFO of {data, request addr}).
module tb_instr_prefetch_queue;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_prefetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clock__i(clk),
    .reset__i(rst),
    .bus     (bus)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct {
    bit redir; logic [31:0] rpc; bit rdy;
    bit req; logic [31:0] addr; bit val; logic [31:0] pc;
  } vec_t;

  req_t        mq[$];
  ent_t        fq[$];
  logic [31:0] m_fpc;
  int          cyc, lat_fix;
  int          total, bad;
  logic [31:0] iss_log[$], pop_log[$], pp4_log[$], ins_log[$];
  logic        o_req, o_val;
  logic [31:0] o_addr, o_pc;
  vec_t        tbl[16];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, update model at posedge.
  task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit g);
    bit   rv, e_req, e_val;
    req_t h;
    int   lat;
    rst                   = r;
    bus.redirect__i       = redir;
    bus.redirectPc__i     = rpc;
    bus.instrReady__i     = rdy;
    bus.imemGnt__i        = g;
    rv = !r && (mq.size() != 0) && (mq[0].due <= cyc);
    bus.imemRvalid__i = rv;
    if (rv) bus.imemRdata__i = mem_data(mq[0].addr);
    else    bus.imemRdata__i = $urandom;
    e_req = !r && !redir && ((fq.size() + mq.size()) < DEPTH);
    e_val = !r && (fq.size() != 0);
    #1;
    o_req = bus.imemReq__o; o_val = bus.instrValid__o;
    o_addr = bus.imemAddr__o; o_pc = bus.pc__o;
    chk("req", {31'b0, o_req}, {31'b0, e_req});
    if (e_req) chk("addr", o_addr, m_fpc);
    chk("valid", {31'b0, o_val}, {31'b0, e_val});
    if (e_val) begin
      chk("pc", o_pc, fq[0].pc);
      chk("instr", bus.instr__o, fq[0].instr);
      chk("pc4", bus.pcPlus4__o, fq[0].pc + 32'd4);
    end
    if (o_req && g) iss_log.push_back(o_addr);
    if (o_val && rdy && !redir) begin
      pop_log.push_back(o_pc);
      pp4_log.push_back(bus.pcPlus4__o);
      ins_log.push_back(bus.instr__o);
    end
    @(posedge clk);
    lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
    if (r) begin
      mq.delete(); fq.delete(); m_fpc = RPC;
    end else begin
      if (rv) h = mq.pop_front();
      if (redir) begin
        fq.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        m_fpc = rpc;
      end else begin
        if (e_val && rdy) void'(fq.pop_front());
        if (rv && !h.stale) begin
          chk("no_overflow", {31'b0, fq.size() < DEPTH}, 32'd1);
          fq.push_back('{instr: mem_data(h.addr), pc: h.addr});
        end
        if (e_req && g) begin
          mq.push_back('{addr: m_fpc, due: cyc + lat, stale: 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] tmp, rpc;
    total = 0; bad = 0; cyc = 0; lat_fix = 1; m_fpc = RPC;
    // 1-cycle memory, gnt=1: stall decode, then drain, then redirect.
    tbl[0]  = '{0, 32'h0,   0, 1, 32'h0,   0, 32'h0};
    tbl[1]  = '{0, 32'h0,   0, 1, 32'h4,   0, 32'h0};
    tbl[2]  = '{0, 32'h0,   0, 1, 32'h8,   1, 32'h0};
    tbl[3]  = '{0, 32'h0,   0, 1, 32'hC,   1, 32'h0};
    tbl[4]  = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h0};
    tbl[5]  = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h0};
    tbl[6]  = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h0};
    tbl[7]  = '{0, 32'h0,   1, 0, 32'h0,   1, 32'h0};
    tbl[8]  = '{0, 32'h0,   1, 1, 32'h10,  1, 32'h4};
    tbl[9]  = '{0, 32'h0,   1, 1, 32'h14,  1, 32'h8};
    tbl[10] = '{0, 32'h0,   1, 1, 32'h18,  1, 32'hC};
    tbl[11] = '{0, 32'h0,   1, 1, 32'h1C,  1, 32'h10};
    tbl[12] = '{1, 32'h100, 1, 0, 32'h0,   1, 32'h14};
    tbl[13] = '{0, 32'h0,   1, 1, 32'h100, 0, 32'h0};
    tbl[14] = '{0, 32'h0,   1, 1, 32'h104, 0, 32'h0};
    tbl[15] = '{0, 32'h0,   1, 1, 32'h108, 1, 32'h100};

    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, o_req}, 32'd0);
    chk("rst_valid", {31'b0, o_val}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, 1);
      chk("tbl_req", {31'b0, o_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk("tbl_addr", o_addr, tbl[i].addr);
      chk("tbl_valid", {31'b0, o_val}, {31'b0, tbl[i].val});
      if (tbl[i].val) chk("tbl_pc", o_pc, tbl[i].pc);
    end

    // Slow memory: three stale requests dropped after redirect.
    lat_fix = 4;
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h20, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    pop_log.delete(); ins_log.delete();
    step(0, 1, 32'h100, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);
    chk("redir_pops", {31'b0, pop_log.size() != 0}, 32'd1);
    if (pop_log.size() != 0) begin
      chk("redir_first_pc", pop_log[0], 32'h100);
      chk("redir_first_instr", ins_log[0], mem_data(32'h100));
    end
    n = 0;
    foreach (pop_log[i]) if (pop_log[i] >= 32'h20 && pop_log[i] <= 32'h2C) n++;
    chk("redir_no_stale", n, 0);

    // Redirect in the same cycle as a response and a pop.
    lat_fix = 1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    iss_log.delete();
    step(0, 1, 32'h200, 1, 1);
    chk("coinc_kill_valid", {31'b0, bus.instrValid__o}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    chk("coinc_first_issue", (iss_log.size() != 0) ? iss_log[0] : 32'hDEAD_BEEF, 32'h200);

    // Fetch address wraps around the top of the address space.
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFF8, 0, 1);
    iss_log.delete(); pop_log.delete(); pp4_log.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    chk("wrap_n", {31'b0, iss_log.size() >= 3 && pp4_log.size() >= 2}, 32'd1);
    if (iss_log.size() >= 3 && pp4_log.size() >= 2) begin
      chk("wrap_a0", iss_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", iss_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", iss_log[2], 32'h0);
      chk("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
      chk("wrap_pc4", pp4_log[1], 32'h0);
    end

    // Reset with two entries buffered and two requests in flight.
    lat_fix = 3;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("pre_rst_fifo", fq.size(), 2);
    chk("pre_rst_inflight", mq.size(), 2);
    step(1, 0, 0, 0, 1);
    chk("mid_rst_req", {31'b0, o_req}, 32'd0);
    step(1, 0, 0, 0, 1);
    chk("post_rst_req", {31'b0, o_req}, 32'd0);
    chk("post_rst_valid", {31'b0, o_val}, 32'd0);
    step(0, 0, 0, 1, 1);
    chk("restart_req", {31'b0, o_req}, 32'd1);
    chk("restart_addr", o_addr, RPC);

    // Randomized traffic with variable latency, grants and redirects.
    lat_fix = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tmp = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'b0, tmp[3:2], 2'b00};
      else                           rpc = {tmp[31:2], 2'b00};
      step(0, $urandom_range(0, 99) < 3, rpc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
